// File: rtl/ram1_core_arbiter.sv
// Round-robin arbiter sharing the single 1-bit ram1 port among NCORES cores,
// with per-core lock for read-modify-write and a bounded lock tenure.
module ram1_core_arbiter #(
  parameter int NCORES   = 4,
  parameter int ADDR_W   = 14,
  parameter int LOCK_MAX = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCORES-1:0]        req,
  input  logic [NCORES-1:0]        we,
  input  logic [NCORES*ADDR_W-1:0] addr,
  input  logic [NCORES-1:0]        wdata,
  input  logic [NCORES-1:0]        lock,
  input  logic                     mem_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_wdata,
  output logic                     mem_store,
  output logic [NCORES-1:0]        grant,
  output logic [NCORES-1:0]        rdata,
  output logic [NCORES-1:0]        rvalid,
  output logic                     lock_err
);

  localparam int PTR_W = $clog2(NCORES);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [CNT_W-1:0] lock_cnt;

  logic              arb_en;
  logic              force_rel;
  logic              hold_owner;
  logic [NCORES-1:0] mask;
  logic [PTR_W:0]    pick_res;
  logic              win;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  next_ptr;

  // Returns {found, index} of the first set bit of r at or above ptr, wrapping.
  // Scanning offsets high-to-low lets the smallest offset overwrite last.
  function automatic logic [PTR_W:0] pick(input logic [NCORES-1:0] r,
                                          input logic [PTR_W-1:0]  ptr);
    logic [PTR_W:0] res;
    int             idx;
    res = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NCORES) idx = idx - NCORES;
      if (r[idx]) res = {1'b1, PTR_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    arb_en     = 1'b0;
    force_rel  = 1'b0;
    hold_owner = 1'b0;
    mask       = req;
    if (state == ARB || !lock[owner]) begin
      arb_en = 1'b1;
    end else if (lock_cnt >= CNT_W'(LOCK_MAX)) begin
      // Tenure exhausted: release and keep the owner out of this edge's pick.
      arb_en    = 1'b1;
      force_rel = 1'b1;
      mask      = req & ~(NCORES'(1) << owner);
    end else begin
      hold_owner = req[owner];
    end
    pick_res = pick(mask, rr_ptr);
    win      = arb_en ? pick_res[PTR_W] : hold_owner;
    win_idx  = arb_en ? pick_res[PTR_W-1:0] : owner;
    next_ptr = (win_idx == PTR_W'(NCORES - 1)) ? '0 : win_idx + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      lock_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= 1'b0;
      mem_store <= 1'b0;
      grant     <= '0;
      rdata     <= '0;
      rvalid    <= '0;
      lock_err  <= 1'b0;
    end else begin
      // Stage 0: arbitration and issue to ram1
      lock_err <= force_rel;
      if (win) begin
        mem_addr  <= addr[int'(win_idx)*ADDR_W +: ADDR_W];
        mem_wdata <= wdata[win_idx];
        mem_store <= we[win_idx];
        grant     <= NCORES'(1) << win_idx;
        rr_ptr    <= next_ptr;
        if (arb_en) begin
          if (lock[win_idx]) begin
            state    <= LOCKED;
            owner    <= win_idx;
            lock_cnt <= CNT_W'(1);
          end else begin
            state    <= ARB;
            lock_cnt <= '0;
          end
        end else begin
          lock_cnt <= lock_cnt + CNT_W'(1);
        end
      end else begin
        grant     <= '0;
        mem_store <= 1'b0;
        if (arb_en) begin
          state    <= ARB;
          lock_cnt <= '0;
        end
      end

      // Stage 1: capture load data for the core granted last cycle
      rvalid <= mem_store ? '0 : grant;
      for (int i = 0; i < NCORES; i++) begin
        if (grant[i] && !mem_store) rdata[i] <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram1_core_arbiter.sv
// Directed bench for ram1_core_arbiter: reset, store, load, round-robin, lock and forced release.
module tb_ram1_core_arbiter;

  localparam int NCORES   = 4;
  localparam int ADDR_W   = 14;
  localparam int LOCK_MAX = 8;

  logic                     clk;
  logic                     reset;
  logic [NCORES-1:0]        req;
  logic [NCORES-1:0]        we;
  logic [NCORES*ADDR_W-1:0] addr;
  logic [NCORES-1:0]        wdata;
  logic [NCORES-1:0]        lock;
  logic                     mem_rdata;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_wdata;
  logic                     mem_store;
  logic [NCORES-1:0]        grant;
  logic [NCORES-1:0]        rdata;
  logic [NCORES-1:0]        rvalid;
  logic                     lock_err;

  int checks;
  int errors;

  ram1_core_arbiter #(
    .NCORES  (NCORES),
    .ADDR_W  (ADDR_W),
    .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .lock     (lock),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_store(mem_store),
    .grant    (grant),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .lock_err (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [NCORES-1:0] exp_grant;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; lock = '0; mem_rdata = 1'b0;
    cycle();
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_store", 32'(mem_store), 32'h0);
    check("reset_rvalid", 32'(rvalid), 32'h0);
    check("reset_addr", 32'(mem_addr), 32'h0);
    check("reset_lock_err", 32'(lock_err), 32'h0);
    reset = 1'b1;
    cycle();

    // Core2 store
    req[2] = 1'b1; we[2] = 1'b1; wdata[2] = 1'b1; addr[2*ADDR_W +: ADDR_W] = 14'h0015;
    cycle();
    check("st_grant", 32'(grant), 32'h4);
    check("st_store", 32'(mem_store), 32'h1);
    check("st_addr", 32'(mem_addr), 32'h15);
    check("st_wdata", 32'(mem_wdata), 32'h1);
    req = '0; we = '0; wdata = '0;
    cycle();
    check("st_idle_store", 32'(mem_store), 32'h0);
    check("st_no_rvalid", 32'(rvalid), 32'h0);
    check("st_addr_hold", 32'(mem_addr), 32'h15);

    // Core1 load
    req[1] = 1'b1; addr[1*ADDR_W +: ADDR_W] = 14'h0003; mem_rdata = 1'b1;
    cycle();
    check("ld_grant", 32'(grant), 32'h2);
    check("ld_store", 32'(mem_store), 32'h0);
    check("ld_addr", 32'(mem_addr), 32'h3);
    req = '0;
    cycle();
    check("ld_rvalid", 32'(rvalid), 32'h2);
    check("ld_rdata1", 32'(rdata[1]), 32'h1);
    check("ld_grant_off", 32'(grant), 32'h0);
    mem_rdata = 1'b0;
    cycle();
    check("ld_rvalid_pulse", 32'(rvalid), 32'h0);
    check("ld_rdata_hold", 32'(rdata[1]), 32'h1);

    // Reset in the middle of a load
    req[0] = 1'b1; addr[0 +: ADDR_W] = 14'h0007; mem_rdata = 1'b1;
    cycle();
    check("rst_pre_grant", 32'(grant), 32'h1);
    reset = 1'b0;
    #1;
    check("rst_async_grant", 32'(grant), 32'h0);
    check("rst_async_rdata", 32'(rdata), 32'h0);
    check("rst_async_addr", 32'(mem_addr), 32'h0);
    req = '0;
    cycle();
    reset = 1'b1;
    cycle();
    check("rst_no_rvalid", 32'(rvalid), 32'h0);
    check("rst_no_store", 32'(mem_store), 32'h0);
    mem_rdata = 1'b0;

    // All cores requesting: strict rotation from pointer 0
    req = 4'b1111; we = 4'b1010;
    for (int i = 0; i < NCORES; i++) addr[i*ADDR_W +: ADDR_W] = ADDR_W'(14'h0100 + i);
    for (int k = 0; k < 8; k++) begin
      cycle();
      exp_grant = NCORES'(1) << (k % NCORES);
      check($sformatf("rr_grant_%0d", k), 32'(grant), 32'(exp_grant));
      check($sformatf("rr_store_%0d", k), 32'(mem_store), 32'(we[k % NCORES]));
    end
    req = '0; we = '0;
    cycle();
    cycle();

    // Core3 lock: others blocked until lock drops, then core0 wins
    req = 4'b1000; lock = 4'b1000;
    cycle();
    check("lk_first", 32'(grant), 32'h8);
    req = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      cycle();
      check($sformatf("lk_hold_%0d", k), 32'(grant), 32'h8);
    end
    req = 4'b0111;
    cycle();
    check("lk_blocked", 32'(grant), 32'h0);
    lock = '0;
    cycle();
    check("lk_release", 32'(grant), 32'h1);
    check("lk_no_err", 32'(lock_err), 32'h0);
    req = '0;
    cycle();
    cycle();

    // Core0 holds lock past LOCK_MAX: forced release to core1
    req = 4'b0001; lock = 4'b0001;
    cycle();
    check("fr_grant_1", 32'(grant), 32'h1);
    req = 4'b0011;
    for (int k = 2; k <= LOCK_MAX; k++) begin
      cycle();
      check($sformatf("fr_grant_%0d", k), 32'(grant), 32'h1);
      check($sformatf("fr_err_low_%0d", k), 32'(lock_err), 32'h0);
    end
    cycle();
    check("fr_handoff", 32'(grant), 32'h2);
    check("fr_err_pulse", 32'(lock_err), 32'h1);
    req = 4'b0001;
    cycle();
    check("fr_relock", 32'(grant), 32'h1);
    check("fr_err_clear", 32'(lock_err), 32'h0);
    req = '0; lock = '0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
